// File: rtl/udp_read_ctrl.sv
// udp_read_ctrl
//   Read-side controller between the ADC capture FIFO and the UDP transmitter.
//   Once the FIFO reports full, the FIFO is drained one byte per cycle into a
//   2-entry output buffer. The buffer absorbs the one-cycle read latency, so no
//   byte is lost when the transmitter applies udp_busy backpressure. The stream
//   is cut into packets of at most PAYLOAD_BYTES, and GAP_CYCLES idle cycles
//   follow every packet.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | waiting for the FIFO full flag
//   DRAIN | reading the FIFO and offering bytes to the UDP transmitter
//   GAP   | inter-packet idle time, no reads and no offers
//
// Ports
//   clk        read clock; all logic runs on the rising edge
//   rst        synchronous active-high reset
//   full       FIFO full flag (starts a drain)
//   empty      FIFO empty flag
//   rd_en      FIFO read strobe; data returns one cycle later with valid
//   valid      FIFO read-data valid
//   din        FIFO read data
//   udp_busy   UDP transmitter is not accepting this cycle
//   tx_valid   byte offered to the UDP transmitter
//   tx_data    offered byte (buffer head)
//   tx_last    offered byte ends the current packet
//   eth_en     high in DRAIN and GAP
//   state      0 IDLE, 1 DRAIN, 2 GAP
//   pkt_count  packets completed since reset (wraps)
module udp_read_ctrl #(
  parameter int DATA_W        = 8,
  parameter int PAYLOAD_BYTES = 1024,
  parameter int GAP_CYCLES    = 12,
  parameter int CNT_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              full,
  input  logic              empty,
  output logic              rd_en,
  input  logic              valid,
  input  logic [DATA_W-1:0] din,
  input  logic              udp_busy,
  output logic              tx_valid,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_last,
  output logic              eth_en,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  pkt_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] PAYLOAD_C = CNT_W'(PAYLOAD_BYTES);
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(PAYLOAD_BYTES - 1);

  state_t state_q, state_d;

  // buf0_q is always the head when occ_q > 0
  logic [DATA_W-1:0] buf0_q, buf1_q;
  logic [1:0]        occ_q;
  logic [1:0]        inf_q;

  // byte_cnt_q: bytes already accepted in this packet (head is byte_cnt_q+1)
  // issued_q:   reads issued in this packet, capped at PAYLOAD_BYTES
  logic [CNT_W-1:0]  byte_cnt_q;
  logic [CNT_W-1:0]  issued_q;
  logic [CNT_W-1:0]  pkt_count_q;
  logic [GAP_W-1:0]  gap_cnt_q;

  logic       accept;
  logic       push;
  logic       pop;
  logic       pkt_done;
  logic       gap_done;
  logic [2:0] room;

  assign accept   = tx_valid & ~udp_busy;
  assign pop      = accept;
  // A valid with no read outstanding (e.g. a read issued just before reset)
  // is dropped so stale data never reaches the buffer.
  assign push     = valid & (inf_q != 2'd0);
  assign pkt_done = accept & tx_last;
  assign gap_done = (state_q == S_GAP) && (gap_cnt_q == '0);

  // Buffer plus in-flight reads after this cycle's pop must leave a free slot
  // for the read being issued, so the 2-entry buffer can never overflow.
  assign room = 3'(occ_q) + 3'(inf_q) - 3'(accept);

  assign tx_valid = (state_q == S_DRAIN) && (occ_q != 2'd0);
  assign tx_data  = buf0_q;
  assign tx_last  = tx_valid &&
                    ((byte_cnt_q == LAST_IDX) ||
                     (empty && (inf_q == 2'd0) && (occ_q == 2'd1)));

  assign rd_en = (state_q == S_DRAIN) && !empty && !udp_busy &&
                 (room < 3'd2) && (issued_q < PAYLOAD_C);

  assign eth_en    = (state_q == S_DRAIN) || (state_q == S_GAP);
  assign state     = state_q;
  assign pkt_count = pkt_count_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (full) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (pkt_done) state_d = S_GAP;
      end
      S_GAP: begin
        if (gap_done) state_d = empty ? S_IDLE : S_DRAIN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gap_cnt_q <= '0;
    end else if (pkt_done) begin
      gap_cnt_q <= GAP_LOAD;
    end else if ((state_q == S_GAP) && (gap_cnt_q != '0)) begin
      gap_cnt_q <= gap_cnt_q - GAP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt_q  <= '0;
      issued_q    <= '0;
      pkt_count_q <= '0;
    end else begin
      if (pkt_done) begin
        byte_cnt_q  <= '0;
        pkt_count_q <= pkt_count_q + CNT_W'(1);
      end else if (accept) begin
        byte_cnt_q <= byte_cnt_q + CNT_W'(1);
      end

      // rd_en is never high on the closing cycle: either all reads of the
      // packet were issued already or the FIFO is empty.
      if (pkt_done) begin
        issued_q <= '0;
      end else if (rd_en) begin
        issued_q <= issued_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inf_q <= 2'd0;
    end else begin
      inf_q <= inf_q + 2'(rd_en) - 2'(push);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf0_q <= '0;
      buf1_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      case ({push, pop})
        2'b11: begin
          if (occ_q == 2'd2) begin
            buf0_q <= buf1_q;
            buf1_q <= din;
          end else begin
            buf0_q <= din;
          end
        end
        2'b10: begin
          if (occ_q == 2'd0) begin
            buf0_q <= din;
          end else if (occ_q == 2'd1) begin
            buf1_q <= din;
          end
        end
        2'b01: begin
          buf0_q <= buf1_q;
        end
        default: ;
      endcase
      if (push && !pop && (occ_q != 2'd2)) begin
        occ_q <= occ_q + 2'd1;
      end else if (pop && !push) begin
        occ_q <= occ_q - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_udp_read_ctrl.sv
module tb_udp_read_ctrl;

  localparam int P  = 4;
  localparam int G  = 5;
  localparam int DW = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          full;
  logic          empty;
  logic          rd_en;
  logic          valid;
  logic [DW-1:0] din;
  logic          udp_busy;
  logic          tx_valid;
  logic [DW-1:0] tx_data;
  logic          tx_last;
  logic          eth_en;
  logic [1:0]    state;
  logic [CW-1:0] pkt_count;

  udp_read_ctrl #(
    .DATA_W        (DW),
    .PAYLOAD_BYTES (P),
    .GAP_CYCLES    (G),
    .CNT_W         (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .full      (full),
    .empty     (empty),
    .rd_en     (rd_en),
    .valid     (valid),
    .din       (din),
    .udp_busy  (udp_busy),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_last   (tx_last),
    .eth_en    (eth_en),
    .state     (state),
    .pkt_count (pkt_count)
  );

  always #4 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // FIFO model: one-cycle read latency, empty derived from pointers
  logic [DW-1:0] fifo_mem [0:15];
  int            fifo_rd  = 0;
  int            fifo_wr  = 0;
  logic          fifo_clr = 1'b0;

  assign empty = (fifo_rd >= fifo_wr);

  always @(posedge clk) begin
    valid <= 1'b0;
    if (fifo_clr) begin
      fifo_rd <= 0;
    end else if (rd_en && (fifo_rd < fifo_wr)) begin
      din     <= fifo_mem[fifo_rd];
      valid   <= 1'b1;
      fifo_rd <= fifo_rd + 1;
    end
  end

  // scoreboard entries: {last, data}
  logic [DW:0] exp_q [$];
  int          acc_n = 0;

  initial begin : monitor
    logic [DW:0]   e;
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    bit            gap_track;
    int            gap_n;
    prev_stall = 1'b0;
    prev_data  = '0;
    gap_track  = 1'b0;
    gap_n      = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
        gap_track  = 1'b0;
      end else begin
        if (prev_stall && tx_valid) check("hold_data", 32'(tx_data), 32'(prev_data));
        prev_stall = tx_valid & udp_busy;
        prev_data  = tx_data;
        if (gap_track) begin
          if (state == 2'd2) begin
            gap_n++;
            check("gap_quiet", 32'(tx_valid), 0);
          end else begin
            check("gap_len", gap_n, G);
            gap_track = 1'b0;
          end
        end
        if (tx_valid && !udp_busy) begin
          check("sb_nonempty", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("tx_data", 32'(tx_data), 32'(e[DW-1:0]));
            check("tx_last", 32'(tx_last), 32'(e[DW]));
          end
          acc_n++;
          if (tx_last) begin
            gap_track = 1'b1;
            gap_n     = 0;
          end
        end
      end
    end
  end

  task automatic fill(input int n, input int n_exp);
    bit last;
    fifo_clr = 1'b1;
    fifo_wr  = 0;
    @(posedge clk);
    #1;
    fifo_clr = 1'b0;
    for (int i = 0; i < n; i++) fifo_mem[i] = 8'(i);
    fifo_wr = n;
    for (int i = 0; i < n_exp; i++) begin
      last = ((i % P) == P - 1) || (i == n - 1);
      exp_q.push_back({last, 8'(i)});
    end
  endtask

  task automatic pulse_full();
    @(posedge clk);
    #1 full = 1'b1;
    @(posedge clk);
    #1 full = 1'b0;
  endtask

  task automatic run_drain(input bit toggle, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(posedge clk);
      #1;
      if (toggle) udp_busy = ~udp_busy;
      if ((state == 2'd0) && (exp_q.size() == 0)) done = 1'b1;
    end
    udp_busy = 1'b0;
    check("drain_done", 32'(done), 1);
  endtask

  initial begin : main
    int  base;
    bit  hit;
    rst      = 1'b1;
    full     = 1'b0;
    udp_busy = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_en", 32'(rd_en), 0);
    check("rst_tx_valid", 32'(tx_valid), 0);
    check("rst_tx_last", 32'(tx_last), 0);
    check("rst_eth_en", 32'(eth_en), 0);
    check("rst_state", 32'(state), 0);
    check("rst_pkt_count", 32'(pkt_count), 0);
    rst = 1'b0;

    // FIFO holds data but full never rises: nothing may be read
    fill(10, 10);
    repeat (8) begin
      @(posedge clk);
      #1;
      check("nofull_rd_en", 32'(rd_en), 0);
      check("nofull_state", 32'(state), 0);
    end

    // 10 bytes, no backpressure: packets 0..3, 4..7, 8..9
    pulse_full();
    check("drain_state", 32'(state), 1);
    check("drain_eth_en", 32'(eth_en), 1);
    run_drain(1'b0, 400);
    check("t1_pkt_count", 32'(pkt_count), 3);
    check("t1_state", 32'(state), 0);
    check("t1_sb_empty", exp_q.size(), 0);

    // Same fill with udp_busy toggling every cycle
    fill(10, 10);
    pulse_full();
    run_drain(1'b1, 800);
    check("t2_pkt_count", 32'(pkt_count), 6);
    check("t2_state", 32'(state), 0);
    check("t2_sb_empty", exp_q.size(), 0);

    // Reset mid-drain once byte 5 has been accepted
    fill(10, 6);
    base = acc_n;
    hit  = 1'b0;
    pulse_full();
    for (int i = 0; i < 200 && !hit; i++) begin
      @(posedge clk);
      #1;
      if (acc_n - base >= 6) hit = 1'b1;
    end
    check("mid_reached", 32'(hit), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_tx_valid", 32'(tx_valid), 0);
    check("mid_rd_en", 32'(rd_en), 0);
    check("mid_state", 32'(state), 0);
    check("mid_pkt_count", 32'(pkt_count), 0);
    check("mid_eth_en", 32'(eth_en), 0);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;

    // Short drain: 2 bytes form one packet
    fill(2, 2);
    pulse_full();
    run_drain(1'b0, 200);
    check("t4_pkt_count", 32'(pkt_count), 1);
    check("t4_state", 32'(state), 0);
    check("t4_sb_empty", exp_q.size(), 0);

    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
